// File: rtl/huffman_decoder_if.sv
// Table-load, serial-bit and decoded-symbol signals of huffman_decoder.
// The master drives the table, bits and sym_ready. The slave is the decoder.
interface huffman_decoder_if;
  logic        code_valid;
  logic [7:0]  HC1, HC2, HC3, HC4, HC5, HC6;
  logic [7:0]  M1, M2, M3, M4, M5, M6;
  logic        bit_valid;
  logic        bit_in;
  logic        bit_ready;
  logic        sym_valid;
  logic [2:0]  sym;
  logic        sym_ready;
  logic        err;
  logic        tbl_err;
  logic [15:0] sym_cnt;

  modport master (
    output code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
    output M1, M2, M3, M4, M5, M6,
    output bit_valid, bit_in, sym_ready,
    input  bit_ready, sym_valid, sym, err, tbl_err, sym_cnt
  );

  modport slave (
    input  code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
    input  M1, M2, M3, M4, M5, M6,
    input  bit_valid, bit_in, sym_ready,
    output bit_ready, sym_valid, sym, err, tbl_err, sym_cnt
  );
endinterface

// File: rtl/huffman_decoder.sv
// Serial MSB-first decoder for a six-entry, up-to-8-bit Huffman table. The symbol is registered in the cycle after its last bit.
// A stalled symbol (sym_valid & !sym_ready) holds bit_ready low, so the accumulator freezes and no bit is lost.
module huffman_decoder (
  input logic              clk,
  input logic              reset,
  huffman_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, TERR} state_t;

  state_t          state_q;
  logic [5:0][7:0] hc_q;
  logic [5:0][7:0] m_q;
  logic [7:0]      acc_q;
  logic [3:0]      len_q;
  logic            sym_valid_q;
  logic [2:0]      sym_q;
  logic            err_q;
  logic            tbl_err_q;
  logic [15:0]     sym_cnt_q;

  logic [5:0][7:0] hc_in;
  logic [5:0][7:0] m_in;
  logic [7:0]      acc_d;
  logic [3:0]      len_d;
  logic [7:0]      len_mask;
  logic            bit_ready;
  logic            bit_take;
  logic            out_take;
  logic            hit;
  logic [2:0]      hit_sym;
  logic            tbl_ok;

  assign hc_in = {bus.HC6, bus.HC5, bus.HC4, bus.HC3, bus.HC2, bus.HC1};
  assign m_in  = {bus.M6, bus.M5, bus.M4, bus.M3, bus.M2, bus.M1};

  assign bit_ready = (state_q == RUN) && (!sym_valid_q || bus.sym_ready);
  assign bit_take  = bus.bit_valid && bit_ready;
  assign out_take  = sym_valid_q && bus.sym_ready;
  assign acc_d     = {acc_q[6:0], bus.bit_in};
  assign len_d     = len_q + 4'd1;

  // Mask of the code length the accumulator would have after this bit.
  always_comb begin
    len_mask = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(len_d)) len_mask[i] = 1'b1;
    end
  end

  // The loop runs from the top entry down so that the lowest index wins on duplicates.
  always_comb begin
    hit     = 1'b0;
    hit_sym = 3'd0;
    for (int k = 5; k >= 0; k--) begin
      if (m_q[k] != 8'h00 && m_q[k] == len_mask &&
          (acc_d & m_q[k]) == (hc_q[k] & m_q[k])) begin
        hit     = 1'b1;
        hit_sym = 3'(k + 1);
      end
    end
  end

  // A mask is a run of low ones exactly when m & (m+1) is zero. The zero mask also passes.
  always_comb begin
    tbl_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if ((m_in[k] & (m_in[k] + 8'd1)) != 8'h00) tbl_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hc_q        <= '0;
      m_q         <= '0;
      acc_q       <= '0;
      len_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_q       <= '0;
      err_q       <= 1'b0;
      tbl_err_q   <= 1'b0;
      sym_cnt_q   <= '0;
    end else begin
      err_q <= 1'b0;
      if (bus.code_valid) begin
        hc_q        <= hc_in;
        m_q         <= m_in;
        acc_q       <= '0;
        len_q       <= '0;
        sym_valid_q <= 1'b0;
        sym_cnt_q   <= '0;
        tbl_err_q   <= !tbl_ok;
        state_q     <= tbl_ok ? RUN : TERR;
      end else begin
        if (out_take) begin
          sym_valid_q <= 1'b0;
          sym_cnt_q   <= sym_cnt_q + 16'd1;
        end
        if (bit_take) begin
          if (hit) begin
            sym_q       <= hit_sym;
            sym_valid_q <= 1'b1;
            acc_q       <= '0;
            len_q       <= '0;
          end else if (len_d == 4'd8) begin
            err_q <= 1'b1;
            acc_q <= '0;
            len_q <= '0;
          end else begin
            acc_q <= acc_d;
            len_q <= len_d;
          end
        end
      end
    end
  end

  assign bus.bit_ready = bit_ready;
  assign bus.sym_valid = sym_valid_q;
  assign bus.sym       = sym_q;
  assign bus.err       = err_q;
  assign bus.tbl_err   = tbl_err_q;
  assign bus.sym_cnt   = sym_cnt_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder: expected symbols queue up when bits are driven and are checked on each output handshake.
module tb_huffman_decoder;

  localparam logic [5:0][7:0] BASIC_HC = {8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
  localparam logic [5:0][7:0] BASIC_M  = {8'h1F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
  localparam logic [5:0][7:0] ONE_HC   = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
  localparam logic [5:0][7:0] ONE_M    = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  logic [2:0] exp_q [$];

  huffman_decoder_if u_if ();

  huffman_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table(input logic [5:0][7:0] hc, input logic [5:0][7:0] m);
    u_if.HC1 = hc[0]; u_if.HC2 = hc[1]; u_if.HC3 = hc[2];
    u_if.HC4 = hc[3]; u_if.HC5 = hc[4]; u_if.HC6 = hc[5];
    u_if.M1  = m[0];  u_if.M2  = m[1];  u_if.M3  = m[2];
    u_if.M4  = m[3];  u_if.M5  = m[4];  u_if.M6  = m[5];
    u_if.code_valid = 1'b1;
    tick();
    u_if.code_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string phase);
    check({phase, "_bit_ready"}, 32'(u_if.bit_ready), 0);
    check({phase, "_sym_valid"}, 32'(u_if.sym_valid), 0);
    check({phase, "_sym"},       32'(u_if.sym),       0);
    check({phase, "_err"},       32'(u_if.err),       0);
    check({phase, "_tbl_err"},   32'(u_if.tbl_err),   0);
    check({phase, "_sym_cnt"},   32'(u_if.sym_cnt),   0);
  endtask

  // Scoreboard: every handshake the DUT will complete on the next edge pops one expected symbol.
  always @(negedge clk) begin
    logic [2:0] e;
    if (reset && u_if.sym_valid && u_if.sym_ready && !u_if.code_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_sym", 32'(u_if.sym), 32'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("sb_sym", 32'(u_if.sym), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int basic_bits [8] = '{1, 0, 1, 0, 0, 0, 0, 0};
    int basic_sym  [8] = '{1, 0, 2, 0, 0, 0, 0, 6};
    logic [5:0][7:0] bad_m;

    reset = 1'b0;
    u_if.code_valid = 1'b0;
    u_if.bit_valid  = 1'b0;
    u_if.bit_in     = 1'b0;
    u_if.sym_ready  = 1'b1;
    u_if.HC1 = '0; u_if.HC2 = '0; u_if.HC3 = '0; u_if.HC4 = '0; u_if.HC5 = '0; u_if.HC6 = '0;
    u_if.M1  = '0; u_if.M2  = '0; u_if.M3  = '0; u_if.M4  = '0; u_if.M5  = '0; u_if.M6  = '0;
    #2;
    check_reset_outputs("rst");

    tick();
    reset = 1'b1;
    tick();
    tick();
    check("idle_bit_ready", 32'(u_if.bit_ready), 0);

    // Basic decode: 1 | 01 | 00000 gives symbols 1, 2, 6 at full rate.
    load_table(BASIC_HC, BASIC_M);
    check("load_bit_ready", 32'(u_if.bit_ready), 1);
    check("load_tbl_err",   32'(u_if.tbl_err),   0);
    for (int i = 0; i < 8; i++) begin
      u_if.bit_valid = 1'b1;
      u_if.bit_in    = basic_bits[i][0];
      if (basic_sym[i] != 0) exp_q.push_back(3'(basic_sym[i]));
      tick();
      check("basic_sym_valid", 32'(u_if.sym_valid), 32'(basic_sym[i] != 0));
      if (basic_sym[i] != 0) check("basic_sym", 32'(u_if.sym), 32'(basic_sym[i]));
    end
    u_if.bit_valid = 1'b0;
    tick();
    check("basic_sym_cnt",   32'(u_if.sym_cnt),   3);
    check("basic_idle_valid", 32'(u_if.sym_valid), 0);

    // Backpressure: second bit waits until the first symbol is taken.
    load_table(BASIC_HC, BASIC_M);
    check("bp_cnt_cleared", 32'(u_if.sym_cnt), 0);
    u_if.sym_ready = 1'b0;
    u_if.bit_valid = 1'b1;
    u_if.bit_in    = 1'b1;
    exp_q.push_back(3'd1);
    tick();
    check("bp_first_valid", 32'(u_if.sym_valid), 1);
    check("bp_first_sym",   32'(u_if.sym),       1);
    check("bp_bit_ready",   32'(u_if.bit_ready), 0);
    tick();
    tick();
    check("bp_hold_valid",  32'(u_if.sym_valid), 1);
    check("bp_hold_sym",    32'(u_if.sym),       1);
    check("bp_hold_ready",  32'(u_if.bit_ready), 0);
    check("bp_hold_cnt",    32'(u_if.sym_cnt),   0);
    exp_q.push_back(3'd1);
    u_if.sym_ready = 1'b1;
    tick();
    check("bp_next_valid",  32'(u_if.sym_valid), 1);
    check("bp_next_sym",    32'(u_if.sym),       1);
    check("bp_next_cnt",    32'(u_if.sym_cnt),   1);
    u_if.bit_valid = 1'b0;
    u_if.sym_ready = 1'b0;
    tick();
    check("bp_second_held", 32'(u_if.sym_valid), 1);
    check("bp_second_ready", 32'(u_if.bit_ready), 0);
    u_if.sym_ready = 1'b1;
    tick();
    check("bp_final_cnt",   32'(u_if.sym_cnt),   2);
    check("bp_final_valid", 32'(u_if.sym_valid), 0);

    // Undecodable: eight zeros against a table containing only "1".
    load_table(ONE_HC, ONE_M);
    u_if.bit_valid = 1'b1;
    u_if.bit_in    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("undec_err",       32'(u_if.err),       32'(i == 7));
      check("undec_sym_valid", 32'(u_if.sym_valid), 0);
    end
    u_if.bit_in = 1'b1;
    exp_q.push_back(3'd1);
    tick();
    check("undec_err_pulse", 32'(u_if.err),       0);
    check("undec_recover_v", 32'(u_if.sym_valid), 1);
    check("undec_recover_s", 32'(u_if.sym),       1);
    u_if.bit_valid = 1'b0;
    tick();

    // Bad table: a non-contiguous mask locks out the bit stream.
    bad_m    = BASIC_M;
    bad_m[2] = 8'h05;
    load_table(BASIC_HC, bad_m);
    check("bad_tbl_err",   32'(u_if.tbl_err),   1);
    check("bad_bit_ready", 32'(u_if.bit_ready), 0);
    u_if.bit_valid = 1'b1;
    u_if.bit_in    = 1'b1;
    repeat (4) tick();
    check("bad_tbl_err_hold",   32'(u_if.tbl_err),   1);
    check("bad_bit_ready_hold", 32'(u_if.bit_ready), 0);
    check("bad_no_sym",         32'(u_if.sym_valid), 0);
    u_if.bit_valid = 1'b0;
    load_table(BASIC_HC, BASIC_M);
    check("fix_tbl_err",   32'(u_if.tbl_err),   0);
    check("fix_bit_ready", 32'(u_if.bit_ready), 1);
    u_if.bit_valid = 1'b1;
    u_if.bit_in    = 1'b0;
    tick();
    u_if.bit_in = 1'b1;
    exp_q.push_back(3'd2);
    tick();
    check("fix_sym_valid", 32'(u_if.sym_valid), 1);
    check("fix_sym",       32'(u_if.sym),       2);
    u_if.bit_valid = 1'b0;
    tick();

    // Reload mid-code: the partial "00" is discarded.
    u_if.bit_valid = 1'b1;
    u_if.bit_in    = 1'b0;
    tick();
    tick();
    u_if.bit_valid = 1'b0;
    load_table(BASIC_HC, BASIC_M);
    u_if.bit_valid = 1'b1;
    u_if.bit_in    = 1'b1;
    exp_q.push_back(3'd1);
    tick();
    check("reload_sym_valid", 32'(u_if.sym_valid), 1);
    check("reload_sym",       32'(u_if.sym),       1);
    u_if.bit_valid = 1'b0;
    tick();

    // Async reset with a pending symbol: the symbol is dropped and the table is forgotten.
    u_if.sym_ready = 1'b0;
    u_if.bit_valid = 1'b1;
    u_if.bit_in    = 1'b1;
    tick();
    u_if.bit_valid = 1'b0;
    check("pre_reset_valid", 32'(u_if.sym_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async");
    tick();
    reset = 1'b1;
    u_if.sym_ready = 1'b1;
    u_if.bit_valid = 1'b1;
    u_if.bit_in    = 1'b1;
    repeat (3) tick();
    check("post_reset_ready", 32'(u_if.bit_ready), 0);
    check("post_reset_valid", 32'(u_if.sym_valid), 0);
    u_if.bit_valid = 1'b0;
    load_table(BASIC_HC, BASIC_M);
    check("post_load_ready", 32'(u_if.bit_ready), 1);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
